nvic_service_ctrl: RTL



---
 rtl/nvic_pkg.sv | 20 ++
 rtl/nvic_vec_decoder.sv | 18 +
 rtl/nvic_service_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/nvic_pkg.sv
// Shared constants, state encoding and vector helpers for the interrupt service controller.
package nvic_pkg;

  localparam int NUM_SRC = 11;
  localparam int VEC_W   = 4;

  localparam logic [VEC_W-1:0] VEC_NONE = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // A vector names a real source only when it lies in 1..NUM_SRC.
  function automatic logic vec_valid(input logic [VEC_W-1:0] v);
    return (v != VEC_NONE) && (int'(v) <= NUM_SRC);
  endfunction

endpackage

// File: rtl/nvic_vec_decoder.sv
// Vector to one-hot decoder; produces the pending-clear vector for the serviced source.
module nvic_vec_decoder
  import nvic_pkg::*;
(
  input  logic               i_en,
  input  logic [VEC_W-1:0]   i_vec,
  output logic [NUM_SRC-1:0] o_onehot
);

  // Vector k lights bit k-1; zero and out-of-range vectors decode to nothing.
  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      o_onehot[k] = i_en && (i_vec == VEC_W'(k + 1));
    end
  end

endmodule

// File: rtl/nvic_service_ctrl.sv
// Core-side interrupt service controller: edge capture, masking, request/ack
// handshake with the core and in-service tracking until return-from-interrupt.
//
// state   | meaning
// IDLE    | no request outstanding; arbitrates on the encoder vector
// REQ     | vector presented to the core, waiting for ack (o_irq = 1)
// SERVICE | handler running, waiting for reti (o_busy = 1)
module nvic_service_ctrl
  import nvic_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_irqLine,
  input  logic               i_maskWr,
  input  logic [NUM_SRC-1:0] i_maskData,
  input  logic [VEC_W-1:0]   i_encVal,
  input  logic               i_gie,
  input  logic               i_ack,
  input  logic               i_reti,
  output logic [NUM_SRC-1:0] o_pend,
  output logic [NUM_SRC-1:0] o_mask,
  output logic               o_irq,
  output logic [VEC_W-1:0]   o_vec,
  output logic               o_busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   w_vec_nxt;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_clr_en;

  assign w_set    = i_irqLine & ~r_prev;
  assign w_clr_en = (r_state == REQ) && i_ack;

  nvic_vec_decoder u_clr_dec (
    .i_en     (w_clr_en),
    .i_vec    (r_vec),
    .o_onehot (w_clr)
  );

  // Latch rising edges as pending; a new edge outranks a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= '0;
      r_pend <= '0;
    end else begin
      r_prev <= i_irqLine;
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  // Enable mask register; only gates what the encoder sees.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mask <= '0;
    end else if (i_maskWr) begin
      r_mask <= i_maskData;
    end
  end

  // Handshake state and presented vector.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_vec   <= VEC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
    end
  end

  // Next-state logic; the vector is frozen from REQ entry until we return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    unique case (r_state)
      IDLE: begin
        if (i_gie && vec_valid(i_encVal)) begin
          w_state_nxt = REQ;
          w_vec_nxt   = i_encVal;
        end
      end
      REQ: begin
        if (i_ack) begin
          w_state_nxt = SERVICE;
        end else if (!i_gie) begin
          w_state_nxt = IDLE;
          w_vec_nxt   = VEC_NONE;
        end
      end
      SERVICE: begin
        if (i_reti) begin
          w_state_nxt = IDLE;
          w_vec_nxt   = VEC_NONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = VEC_NONE;
      end
    endcase
  end

  assign o_pend = r_pend & r_mask;
  assign o_mask = r_mask;
  assign o_irq  = (r_state == REQ);
  assign o_busy = (r_state == SERVICE);
  assign o_vec  = r_vec;

endmodule
